// File: rtl/csr_machine_info.sv
// Machine-mode information and counter CSRs for the RV32 core: misa,
// mhartid, mscratch, mcountinhibit and the 64-bit mcycle/minstret pair.
// Accesses are accepted every cycle; the response (old value or error)
// is registered and appears exactly one cycle after the request.
module csr_machine_info #(
    parameter logic [1:0]  CSR_MISA_MXL  = 2'd1,
    parameter bit          RV32E         = 1'b0,
    parameter bit          RV32M         = 1'b1,
    parameter bit          RV32C         = 1'b1,
    parameter bit          MISA_WRITABLE = 1'b0,
    parameter logic [31:0] HART_ID       = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [1:0]  op_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        instr_ret_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] misa_o
);

    // Access types
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // CSR addresses
    localparam logic [11:0] ADDR_MISA          = 12'h301;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

    // Only CY (bit 0) and IR (bit 2) of mcountinhibit exist.
    localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

    // MXL, U always, M, I or E, C.
    localparam logic [31:0] MISA_RESET = {CSR_MISA_MXL, 9'd0, 1'b1, 7'd0, RV32M,
                                          3'd0, ~RV32E, 3'd0, RV32E, 1'b0, RV32C, 2'd0};

    logic [31:0] r_misa;
    logic [31:0] r_mscratch;
    logic [31:0] r_mcountinhibit;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_hit;
    logic [31:0] w_old;
    logic        w_err;
    logic        w_wr;
    logic [31:0] w_new;
    logic [31:0] w_misa_new;

    // Address decode: select the current value of the addressed CSR.
    always_comb begin
        w_hit = 1'b1;
        w_old = 32'd0;
        case (addr_i)
            ADDR_MISA:          w_old = r_misa;
            ADDR_MCOUNTINHIBIT: w_old = r_mcountinhibit;
            ADDR_MSCRATCH:      w_old = r_mscratch;
            ADDR_MCYCLE:        w_old = r_mcycle[31:0];
            ADDR_MCYCLEH:       w_old = r_mcycle[63:32];
            ADDR_MINSTRET:      w_old = r_minstret[31:0];
            ADDR_MINSTRETH:     w_old = r_minstret[63:32];
            ADDR_MHARTID:       w_old = HART_ID;
            default: begin
                w_hit = 1'b0;
                w_old = 32'd0;
            end
        endcase
    end

    // Legality check and read-modify-write value; modifying ops to the
    // read-only space are illegal even when they would change nothing.
    always_comb begin
        w_err = (!w_hit) || ((op_i != OP_READ) && (addr_i[11:10] == 2'b11));
        w_wr  = req_i && !w_err && (op_i != OP_READ);
        case (op_i)
            OP_WRITE: w_new = wdata_i;
            OP_SET:   w_new = w_old | wdata_i;
            OP_CLEAR: w_new = w_old & ~wdata_i;
            default:  w_new = w_old;
        endcase
    end

    // WARL legalisation of misa: only implemented M and C bits may toggle.
    always_comb begin
        w_misa_new     = MISA_RESET;
        w_misa_new[12] = w_new[12] & RV32M;
        w_misa_new[2]  = w_new[2] & RV32C;
    end

    // Registered response: old value or error, one cycle after the request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= (req_i && !w_err) ? w_old : 32'd0;
            r_err    <= req_i && w_err;
        end
    end

    // misa register; writes are dropped silently when not writable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_misa <= MISA_RESET;
        end else if (MISA_WRITABLE && w_wr && (addr_i == ADDR_MISA)) begin
            r_misa <= w_misa_new;
        end else begin
            r_misa <= r_misa;
        end
    end

    // mscratch: plain 32-bit scratch register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mscratch <= 32'd0;
        end else if (w_wr && (addr_i == ADDR_MSCRATCH)) begin
            r_mscratch <= w_new;
        end else begin
            r_mscratch <= r_mscratch;
        end
    end

    // mcountinhibit: unimplemented bits are forced to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mcountinhibit <= 32'd0;
        end else if (w_wr && (addr_i == ADDR_MCOUNTINHIBIT)) begin
            r_mcountinhibit <= w_new & MCOUNTINHIBIT_MASK;
        end else begin
            r_mcountinhibit <= r_mcountinhibit;
        end
    end

    // mcycle: a write to either half wins over that cycle's increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mcycle <= 64'd0;
        end else if (w_wr && (addr_i == ADDR_MCYCLE)) begin
            r_mcycle <= {r_mcycle[63:32], w_new};
        end else if (w_wr && (addr_i == ADDR_MCYCLEH)) begin
            r_mcycle <= {w_new, r_mcycle[31:0]};
        end else if (!r_mcountinhibit[0]) begin
            r_mcycle <= r_mcycle + 64'd1;
        end else begin
            r_mcycle <= r_mcycle;
        end
    end

    // minstret: counts retirements; a write to either half wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_minstret <= 64'd0;
        end else if (w_wr && (addr_i == ADDR_MINSTRET)) begin
            r_minstret <= {r_minstret[63:32], w_new};
        end else if (w_wr && (addr_i == ADDR_MINSTRETH)) begin
            r_minstret <= {w_new, r_minstret[31:0]};
        end else if (instr_ret_i && !r_mcountinhibit[2]) begin
            r_minstret <= r_minstret + 64'd1;
        end else begin
            r_minstret <= r_minstret;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign misa_o   = r_misa;

endmodule

// File: doc/csr_machine_info.md
Name: csr_machine_info

Overview:
- Parametrised machine-mode CSR unit for the RV32 core.
- Holds MISA, computed at elaboration from ISA parameters and now optionally WARL-writable, plus mhartid, mscratch, mcountinhibit, and 64-bit mcycle/minstret counters.
- Serves a single-cycle-request / registered-response CSR access port driven by the decode stage.
- Exports the live MISA value to the decoder.

Parameters:
- CSR_MISA_MXL, 2'd1: MISA[31:30] machine XLEN encoding.
- RV32E, 0: 1 = embedded base (MISA.E=1, MISA.I=0); 0 = MISA.I=1, MISA.E=0.
- RV32M, 1: M extension implemented (MISA bit 12).
- RV32C, 1: C extension implemented (MISA bit 2).
- MISA_WRITABLE, 0: 1 = bits 12 and 2 are WARL-writable; 0 = MISA fully read-only.
- HART_ID, 32'd0: mhartid value.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  CSR access request, one cycle per access
- op_i  in  2  access type: 00 read, 01 write, 10 set, 11 clear
- addr_i  in  12  CSR address
- wdata_i  in  32  write/set/clear operand
- instr_ret_i  in  1  one instruction retired this cycle
- rvalid_o  out  1  response valid
- rdata_o  out  32  old CSR value
- err_o  out  1  illegal access
- misa_o  out  32  current MISA

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - rvalid_o=0, rdata_o=0, err_o=0.
  - mscratch=0, mcountinhibit=0, mcycle=0, minstret=0.
  - MISA = MISA_RESET:
    - bit2 = RV32C
    - bit4 = RV32E
    - bit8 = !RV32E
    - bit12 = RV32M
    - bit20 = 1 (U)
    - bits31:30 = CSR_MISA_MXL
    - all other bits 0
  - Defaults give 32'h40101104.
- Address map:
  - 0x301 misa
  - 0x320 mcountinhibit
  - 0x340 mscratch
  - 0xB00 mcycle, 0xB80 mcycleh
  - 0xB02 minstret, 0xB82 minstreth
  - 0xF14 mhartid
- Access and response:
  - req_i is always accepted; there is no stall.
  - Response comes exactly one cycle later: rvalid_o=1 for one cycle.
  - rdata_o = CSR value at the request cycle, before any update.
  - rvalid_o is 0 in cycles with no preceding request.
  - Back-to-back requests are legal; each sees the effects of the previous one.
- Modify value: new = wdata (write), old|wdata (set), old&~wdata (clear). A read (op 00) modifies nothing.
- Error (err_o=1, rdata_o=0, no state change) when:
  - the address is unmapped, or
  - a write, set or clear targets 0xF14 (addr[11:10]==2'b11 read-only space).
  - A set or clear with wdata=0 to a read-only CSR is still an error.
- misa write:
  - MISA_WRITABLE=0: write ignored, no error.
  - MISA_WRITABLE=1: new bit12 = new_val[12] & RV32M; new bit2 = new_val[2] & RV32C; all other bits keep MISA_RESET values.
  - misa_o updates the cycle after the request.
- mcountinhibit: only bits 0 (CY) and 2 (IR) are implemented; other bits read 0 and ignore writes.
- mcycle: increments by 1 every cycle when mcountinhibit[0]=0.
- minstret: increments by 1 in cycles with instr_ret_i=1 and mcountinhibit[2]=0.
- Counter arithmetic: both counters are 64-bit and wrap from 2^64-1 to 0; the carry from the low into the high word happens in the same cycle.
- Counter CSR writes: 0xB00/0xB02 write bits 31:0; 0xB80/0xB82 write bits 63:32. The other half keeps its value this cycle, with no increment applied.
- Write vs increment: a write to either half of a counter in the same cycle as an increment takes priority; the increment is dropped that cycle.
- Inhibit timing: a write to mcountinhibit takes effect from the next cycle's increment decision.
- Reset mid-operation: all state returns to reset values immediately; a pending response is discarded (rvalid_o=0).

Test Plan:
- Reset with defaults, then read 0x301 -> rvalid_o=1 one cycle later, rdata_o=32'h40101104, err_o=0. With RV32E=1, RV32M=0, RV32C=0 -> 32'h40100010.
- MISA_WRITABLE=1: clear 0x301 with 32'h00001004, then read -> 32'h40100100. Set with 32'hFFFFFFFF, then read -> 32'h40101104. With MISA_WRITABLE=0 the clear leaves 32'h40101104.
- Write mscratch 32'hDEADBEEF, back-to-back read -> write response rdata_o=0, read response rdata_o=32'hDEADBEEF. Set 32'h0000000F, then read -> 32'hDEADBEEF.
- Write 0xB00=32'hFFFFFFFE and 0xB80=0, let 3 cycles elapse -> mcycleh reads 1, low word wrapped through 0. Set mcountinhibit bit0 -> mcycle frozen over 10 cycles.
- Hold instr_ret_i=1 for 5 cycles after reset -> minstret=5. Write 0xB02=100 with instr_ret_i=1 in the same cycle -> next read 100, not 101.
- Write to 0xF14 and read of 0x7C0 -> err_o=1, rdata_o=0; mhartid still reads HART_ID. Assert rst_ni mid-request -> rvalid_o=0 and all CSRs at reset values.
